// File: rtl/jk_bank_arbiter_if.sv
// Bundle of requester-side command signals and bank-side results for
// jk_bank_arbiter. The arbiter takes the slave modport; command sources
// (or a bench) take the master modport.
interface jk_bank_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 3
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       lock;
    logic [NREQ*WIDTH-1:0] j_bus;
    logic [NREQ*WIDTH-1:0] k_bus;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic                  busy;
    logic [15:0]           conflicts;

    modport master (
        output req, lock, j_bus, k_bus,
        input  gnt, q, busy, conflicts
    );

    modport slave (
        input  req, lock, j_bus, k_bus,
        output gnt, q, busy, conflicts
    );
endinterface

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: one WIDTH-bit bank of JK flip-flops shared by NREQ
// requesters. A round-robin arbiter with an optional burst lock picks one
// winner per cycle; the winner's per-bit JK command updates the bank at the
// clock edge.
//
// Build option: define JKB_CONFLICT_CNT_EN to build a saturating 16-bit
// counter of cycles with more than one request; otherwise conflicts reads 0.
module jk_bank_arbiter #(
    parameter int WIDTH    = 4,
    parameter int NREQ     = 3,
    parameter int MAX_LOCK = 4
) (
    input  logic          clk,
    input  logic          reset,
    jk_bank_arbiter_if.slave bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_LOCK + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    // Arbitration and bank state
    logic [0:0]       state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    owner_q, owner_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;

    // Arbitration decode
    logic             locked;
    logic             owner_prio;
    logic             forced_exit;
    logic [PW-1:0]    start_idx;
    logic [NREQ-1:0]  cand;
    logic             win_valid;
    logic [PW-1:0]    win_idx;
    logic             xfer;

    // Winner's command and the resulting bank value
    logic [WIDTH-1:0] win_j;
    logic [WIDTH-1:0] win_k;
    logic [WIDTH-1:0] jk_next;

    // Index successor with wrap from NREQ-1 back to 0
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        if (int'(i) == NREQ - 1) begin
            return '0;
        end
        return i + PW'(1);
    endfunction

    assign locked = (state_q == ST_LOCKED);

    // The owner keeps the bank while it still wants it and has burst budget left
    assign owner_prio  = locked && bus.req[owner_q] && bus.lock[owner_q] &&
                         (cnt_q < CW'(MAX_LOCK));
    // Budget exhausted: the owner sits out this cycle
    assign forced_exit = locked && (cnt_q == CW'(MAX_LOCK));

    // On any exit from a burst, the search restarts just after the owner
    assign start_idx = locked ? next_idx(owner_q) : ptr_q;

    // Candidate set for the round-robin search, with the owner masked on forced exit
    always_comb begin
        cand = bus.req;
        if (forced_exit) begin
            cand[owner_q] = 1'b0;
        end
    end

    // Pick the winner: the burst owner if it holds priority, else first candidate from start_idx
    always_comb begin
        int idx;
        idx       = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        if (owner_prio) begin
            win_valid = 1'b1;
            win_idx   = owner_q;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(start_idx) + k) % NREQ;
                if (!win_valid && cand[idx]) begin
                    win_valid = 1'b1;
                    win_idx   = PW'(idx);
                end
            end
        end
    end

    // Reset suppresses every grant and therefore every transfer
    assign xfer = win_valid && !reset;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign bus.gnt[gi] = xfer && (win_idx == PW'(gi));
        end
    endgenerate

    assign win_j = bus.j_bus[int'(win_idx)*WIDTH +: WIDTH];
    assign win_k = bus.k_bus[int'(win_idx)*WIDTH +: WIDTH];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk
            // Per-bit JK: hold, clear, set, toggle
            always_comb begin
                case ({win_j[gi], win_k[gi]})
                    2'b01:   jk_next[gi] = 1'b0;
                    2'b10:   jk_next[gi] = 1'b1;
                    2'b11:   jk_next[gi] = ~q_q[gi];
                    default: jk_next[gi] = q_q[gi];
                endcase
            end
        end
    endgenerate

    assign q_d = xfer ? jk_next : q_q;

    // Burst FSM and round-robin pointer next state
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            ptr_d = next_idx(win_idx);
            if (owner_prio) begin
                cnt_d = cnt_q + CW'(1);
            end else if (bus.lock[win_idx]) begin
                // Fresh burst, possibly re-entered in the same cycle as an exit
                state_d = ST_LOCKED;
                owner_d = win_idx;
                cnt_d   = CW'(1);
            end else begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end else if (locked) begin
            // Owner dropped out and nobody else asked: leave the burst anyway
            state_d = ST_IDLE;
            cnt_d   = '0;
            ptr_d   = next_idx(owner_q);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.busy = locked;

`ifdef JKB_CONFLICT_CNT_EN
    logic [15:0] conf_q, conf_d;
    logic        multi_req;

    // More than one requester active this cycle
    always_comb begin
        int n;
        n = 0;
        for (int i = 0; i < NREQ; i++) begin
            n = n + int'(bus.req[i]);
        end
        multi_req = (n > 1);
    end

    assign conf_d = (multi_req && (conf_q != 16'hFFFF)) ? conf_q + 16'd1 : conf_q;

    // Saturating contention counter
    always_ff @(posedge clk) begin
        if (reset) begin
            conf_q <= '0;
        end else begin
            conf_q <= conf_d;
        end
    end

    assign bus.conflicts = conf_q;
`else
    assign bus.conflicts = 16'd0;
`endif

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: a directed vector table for reset, JK update,
// fairness, burst lock and reset-in-burst, then random traffic checked
// against a behavioural arbitration model.
module tb_jk_bank_arbiter;

    localparam int W  = 4;
    localparam int N  = 3;
    localparam int ML = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    jk_bank_arbiter_if #(.WIDTH(W), .NREQ(N)) bus_if ();

    jk_bank_arbiter #(.WIDTH(W), .NREQ(N), .MAX_LOCK(ML)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int           m_ptr    = 0;
    int           m_owner  = -1;
    int           m_cnt    = 0;
    logic [W-1:0] m_q      = '0;
    int           m_conf   = 0;

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [N-1:0]   lock;
        logic [N*W-1:0] j;
        logic [N*W-1:0] k;
        logic [N-1:0]   gnt;
        logic [W-1:0]   q;
        logic           busy;
    } vec_t;

    vec_t tv[30];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Which requester the arbitration rules select this cycle (-1 = none)
    function automatic int model_winner(input logic r, input logic [N-1:0] rq,
                                        input logic [N-1:0] lk);
        int start;
        int excl;
        int idx;
        if (r) return -1;
        if (m_owner >= 0 && rq[m_owner] && lk[m_owner] && m_cnt < ML) return m_owner;
        start = (m_owner >= 0) ? (m_owner + 1) % N : m_ptr;
        excl  = (m_owner >= 0 && m_cnt == ML) ? m_owner : -1;
        for (int i = 0; i < N; i++) begin
            idx = (start + i) % N;
            if (rq[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    // Apply the clock edge to the model given this cycle's winner
    task automatic model_commit(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                                input logic [N*W-1:0] j, input logic [N*W-1:0] k, input int w);
        bit prio;
        if (r) begin
            m_ptr = 0; m_owner = -1; m_cnt = 0; m_q = '0; m_conf = 0;
            return;
        end
`ifdef JKB_CONFLICT_CNT_EN
        if ($countones(rq) > 1 && m_conf < 65535) m_conf++;
`endif
        if (w >= 0) begin
            prio = (m_owner == w) && lk[w] && m_cnt < ML;
            for (int b = 0; b < W; b++) begin
                if (j[w*W+b] && k[w*W+b])       m_q[b] = ~m_q[b];
                else if (j[w*W+b])              m_q[b] = 1'b1;
                else if (k[w*W+b])              m_q[b] = 1'b0;
            end
            m_ptr = (w + 1) % N;
            if (prio) m_cnt++;
            else if (lk[w]) begin m_owner = w; m_cnt = 1; end
            else begin m_owner = -1; m_cnt = 0; end
        end else if (m_owner >= 0) begin
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
            m_cnt = 0;
        end
    endtask

    // One clock cycle: drive, sample gnt mid-cycle, clock, sample registered outputs
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                        input logic [N*W-1:0] j, input logic [N*W-1:0] k,
                        output logic [N-1:0] g_obs, output logic [N-1:0] g_mod,
                        output logic [W-1:0] q_obs, output logic b_obs,
                        output logic [15:0] c_obs);
        int w;
        reset = r;
        bus_if.req = rq;
        bus_if.lock = lk;
        bus_if.j_bus = j;
        bus_if.k_bus = k;
        #2;
        g_obs = bus_if.gnt;
        w = model_winner(r, rq, lk);
        g_mod = '0;
        if (w >= 0) g_mod[w] = 1'b1;
        @(posedge clk);
        model_commit(r, rq, lk, j, k, w);
        #1;
        q_obs = bus_if.q;
        b_obs = bus_if.busy;
        c_obs = bus_if.conflicts;
    endtask

    function automatic vec_t mk(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                                input logic [N*W-1:0] j, input logic [N*W-1:0] k,
                                input logic [N-1:0] g, input logic [W-1:0] qq, input logic b);
        vec_t v;
        v.rst = r; v.req = rq; v.lock = lk; v.j = j; v.k = k;
        v.gnt = g; v.q = qq; v.busy = b;
        return v;
    endfunction

    initial begin
        logic [N-1:0]   g_obs, g_mod, rq, lk;
        logic [W-1:0]   q_obs;
        logic           b_obs, r;
        logic [15:0]    c_obs;
        logic [N*W-1:0] j, k;

        // Reset held with every requester asking
        tv[0]  = mk(1, 3'b111, 3'b000, 12'hFFF, 12'h000, 3'b000, 4'b0000, 0);
        tv[1]  = mk(1, 3'b111, 3'b000, 12'hFFF, 12'h000, 3'b000, 4'b0000, 0);
        // Single requester JK set, toggle, clear
        tv[2]  = mk(0, 3'b001, 3'b000, 12'h00A, 12'h000, 3'b001, 4'b1010, 0);
        tv[3]  = mk(0, 3'b001, 3'b000, 12'h00F, 12'h00F, 3'b001, 4'b0101, 0);
        tv[4]  = mk(0, 3'b001, 3'b000, 12'h000, 12'h004, 3'b001, 4'b0001, 0);
        // Fairness from reset
        tv[5]  = mk(1, 3'b000, 3'b000, 12'h000, 12'h000, 3'b000, 4'b0000, 0);
        tv[6]  = mk(0, 3'b111, 3'b000, 12'h421, 12'h000, 3'b001, 4'b0001, 0);
        tv[7]  = mk(0, 3'b111, 3'b000, 12'h421, 12'h000, 3'b010, 4'b0011, 0);
        tv[8]  = mk(0, 3'b111, 3'b000, 12'h421, 12'h000, 3'b100, 4'b0111, 0);
        tv[9]  = mk(0, 3'b111, 3'b000, 12'h421, 12'h000, 3'b001, 4'b0111, 0);
        tv[10] = mk(0, 3'b111, 3'b000, 12'h421, 12'h000, 3'b010, 4'b0111, 0);
        tv[11] = mk(0, 3'b111, 3'b000, 12'h421, 12'h000, 3'b100, 4'b0111, 0);
        // Burst by requester 1, forced rotation to 0
        tv[12] = mk(0, 3'b001, 3'b000, 12'h481, 12'h080, 3'b001, 4'b0111, 0);
        tv[13] = mk(0, 3'b011, 3'b010, 12'h481, 12'h080, 3'b010, 4'b1111, 1);
        tv[14] = mk(0, 3'b011, 3'b010, 12'h481, 12'h080, 3'b010, 4'b0111, 1);
        tv[15] = mk(0, 3'b011, 3'b010, 12'h481, 12'h080, 3'b010, 4'b1111, 1);
        tv[16] = mk(0, 3'b011, 3'b010, 12'h481, 12'h080, 3'b010, 4'b0111, 1);
        tv[17] = mk(0, 3'b011, 3'b010, 12'h481, 12'h080, 3'b001, 4'b0111, 0);
        // Reset in the middle of a burst, then search from 0
        tv[18] = mk(0, 3'b011, 3'b010, 12'h481, 12'h080, 3'b010, 4'b1111, 1);
        tv[19] = mk(1, 3'b011, 3'b010, 12'h481, 12'h080, 3'b000, 4'b0000, 0);
        tv[20] = mk(0, 3'b110, 3'b000, 12'h481, 12'h080, 3'b010, 4'b1000, 0);
        // Burst with requester 2 waiting: forced rotation goes to 2
        tv[21] = mk(0, 3'b010, 3'b010, 12'h481, 12'h080, 3'b010, 4'b0000, 1);
        tv[22] = mk(0, 3'b111, 3'b010, 12'h481, 12'h080, 3'b010, 4'b1000, 1);
        tv[23] = mk(0, 3'b111, 3'b010, 12'h481, 12'h080, 3'b010, 4'b0000, 1);
        tv[24] = mk(0, 3'b111, 3'b010, 12'h481, 12'h080, 3'b010, 4'b1000, 1);
        tv[25] = mk(0, 3'b111, 3'b010, 12'h481, 12'h080, 3'b100, 4'b1100, 0);
        tv[26] = mk(0, 3'b111, 3'b010, 12'h481, 12'h080, 3'b001, 4'b1101, 0);
        // Lock released by the owner: round robin from owner+1
        tv[27] = mk(0, 3'b010, 3'b010, 12'h481, 12'h080, 3'b010, 4'b0101, 1);
        tv[28] = mk(0, 3'b011, 3'b000, 12'h481, 12'h080, 3'b001, 4'b0101, 0);
        // Idle bus
        tv[29] = mk(0, 3'b000, 3'b000, 12'h481, 12'h080, 3'b000, 4'b0101, 0);

        bus_if.req = '0; bus_if.lock = '0; bus_if.j_bus = '0; bus_if.k_bus = '0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            step(tv[i].rst, tv[i].req, tv[i].lock, tv[i].j, tv[i].k,
                 g_obs, g_mod, q_obs, b_obs, c_obs);
            $display("vec %0d rst=%b req=%b lock=%b gnt=%b q=%b busy=%b",
                     i, tv[i].rst, tv[i].req, tv[i].lock, g_obs, q_obs, b_obs);
            chk($sformatf("vec%0d_gnt", i), 32'(g_obs), 32'(tv[i].gnt));
            chk($sformatf("vec%0d_q", i), 32'(q_obs), 32'(tv[i].q));
            chk($sformatf("vec%0d_busy", i), 32'(b_obs), 32'(tv[i].busy));
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 39) == 0);
            for (int b = 0; b < N; b++) begin
                rq[b] = ($urandom_range(0, 3) != 0);
                lk[b] = ($urandom_range(0, 4) < 3);
            end
            j = N*W'($urandom);
            k = N*W'($urandom);
            step(r, rq, lk, j, k, g_obs, g_mod, q_obs, b_obs, c_obs);
            $display("rnd %0d rst=%b req=%b lock=%b gnt=%b q=%b busy=%b conflicts=%0d",
                     i, r, rq, lk, g_obs, q_obs, b_obs, c_obs);
            chk($sformatf("rnd%0d_gnt", i), 32'(g_obs), 32'(g_mod));
            chk($sformatf("rnd%0d_q", i), 32'(q_obs), 32'(m_q));
            chk($sformatf("rnd%0d_busy", i), 32'(b_obs), 32'(m_owner >= 0));
            chk($sformatf("rnd%0d_conflicts", i), 32'(c_obs), 32'(m_conf));
        end

`ifdef JKB_CONFLICT_CNT_EN
        // Saturation: more contended cycles than the counter can hold
        step(1, 3'b000, 3'b000, '0, '0, g_obs, g_mod, q_obs, b_obs, c_obs);
        for (int i = 0; i < 70000; i++) begin
            step(0, 3'b011, 3'b000, '0, '0, g_obs, g_mod, q_obs, b_obs, c_obs);
        end
        $display("sat cycles=70000 conflicts=%h", c_obs);
        chk("sat_conflicts", 32'(c_obs), 32'h0000FFFF);
`else
        // Without the counter, contention leaves conflicts at zero
        for (int i = 0; i < 20; i++) begin
            step(0, 3'b011, 3'b000, '0, '0, g_obs, g_mod, q_obs, b_obs, c_obs);
        end
        $display("nocnt cycles=20 conflicts=%h", c_obs);
        chk("nocnt_conflicts", 32'(c_obs), 32'h00000000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
